// File: rtl/dsp_boot_monitor.sv
// DSP boot/heartbeat supervisor: watches DSP reset release and firmware
// heartbeat, requests re-sequencing on faults, and locks out after retries.
module dsp_boot_monitor #(
  parameter logic [19:0] BOOT_TIMEOUT  = 20'hC_3500,
  parameter logic [23:0] HB_TIMEOUT    = 24'h98_9680,
  parameter logic [2:0]  MAX_RETRY     = 3'd3,
  parameter logic [7:0]  REQ_PULSE_LEN = 8'd25
) (
  input  logic       clk_sys,
  input  logic       hard_rst_n,
  input  logic       seq_full_n,
  input  logic       dsp_rstn_state,
  input  logic       dsp_heartbeat,
  output logic       reseq_req,
  output logic       dsp_ok,
  output logic       boot_fail,
  output logic       hb_fail,
  output logic       lockout,
  output logic [2:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_BOOT = 3'd1;
  localparam logic [2:0] S_RUNNING   = 3'd2;
  localparam logic [2:0] S_FAULT     = 3'd3;
  localparam logic [2:0] S_WAIT_SEQ  = 3'd4;
  localparam logic [2:0] S_LOCKOUT   = 3'd5;

  localparam logic [23:0] BOOT_TERM  = {4'd0, BOOT_TIMEOUT} - 24'd1;
  localparam logic [23:0] HB_TERM    = HB_TIMEOUT - 24'd1;
  localparam logic [23:0] PULSE_TERM = {16'd0, REQ_PULSE_LEN} - 24'd1;

  logic [1:0]  rstn_sync_q;
  logic [1:0]  hb_sync_q;
  logic        hb_prev_q;
  logic        rstn_s;
  logic        hb_s;
  logic        hb_edge;

  logic [2:0]  state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic        reseq_q, reseq_d;
  logic        boot_fail_q, boot_fail_d;
  logic        hb_fail_q, hb_fail_d;
  logic [2:0]  retry_q, retry_d;
  logic        dsp_ok_q;
  logic        lockout_q;

  assign rstn_s  = rstn_sync_q[1];
  assign hb_s    = hb_sync_q[1];
  assign hb_edge = hb_s ^ hb_prev_q;

  always_ff @(posedge clk_sys or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      rstn_sync_q <= '0;
      hb_sync_q   <= '0;
      hb_prev_q   <= 1'b0;
    end else begin
      rstn_sync_q <= {rstn_sync_q[0], dsp_rstn_state};
      hb_sync_q   <= {hb_sync_q[0], dsp_heartbeat};
      hb_prev_q   <= hb_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = (tmr_q == '1) ? tmr_q : tmr_q + 24'd1;
    reseq_d     = reseq_q;
    boot_fail_d = boot_fail_q;
    hb_fail_d   = hb_fail_q;
    retry_d     = retry_q;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (seq_full_n) state_d = S_WAIT_BOOT;
      end
      S_WAIT_BOOT: begin
        if (!seq_full_n) state_d = S_IDLE;
        else if (rstn_s) state_d = S_RUNNING;
        else if (tmr_q == BOOT_TERM) begin
          state_d     = S_FAULT;
          boot_fail_d = 1'b1;
        end
      end
      S_RUNNING: begin
        if (hb_edge) tmr_d = '0;
        if (!seq_full_n) state_d = S_IDLE;
        else if (!rstn_s) state_d = S_WAIT_BOOT;
        else if (tmr_q == HB_TERM && !hb_edge) begin
          state_d   = S_FAULT;
          hb_fail_d = 1'b1;
        end
      end
      // No pulse pending here means retries were exhausted on entry
      S_FAULT: begin
        if (!reseq_q) state_d = S_LOCKOUT;
        else if (tmr_q == PULSE_TERM) state_d = S_WAIT_SEQ;
      end
      S_WAIT_SEQ: begin
        if (!seq_full_n) state_d = S_IDLE;
        else if (tmr_q == BOOT_TERM) state_d = S_LOCKOUT;
      end
      S_LOCKOUT: tmr_d = '0;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
    if (state_d != S_FAULT) reseq_d = 1'b0;
    if (state_d == S_FAULT && state_q != S_FAULT && retry_q < MAX_RETRY) begin
      reseq_d = 1'b1;
      retry_d = retry_q + 3'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      reseq_q     <= 1'b0;
      boot_fail_q <= 1'b0;
      hb_fail_q   <= 1'b0;
      retry_q     <= '0;
      dsp_ok_q    <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      reseq_q     <= reseq_d;
      boot_fail_q <= boot_fail_d;
      hb_fail_q   <= hb_fail_d;
      retry_q     <= retry_d;
      dsp_ok_q    <= (state_d == S_RUNNING);
      lockout_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign reseq_req = reseq_q;
  assign dsp_ok    = dsp_ok_q;
  assign boot_fail = boot_fail_q;
  assign hb_fail   = hb_fail_q;
  assign lockout   = lockout_q;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dsp_boot_monitor.sv
// Bench for dsp_boot_monitor: random release times and heartbeat periods
// checked against event times computed from the timing rules.
module tb_dsp_boot_monitor;

  logic       clk;
  logic       rst_n;
  logic       seq;
  logic       rstn_pin;
  logic       hb;
  logic       reseq_req;
  logic       dsp_ok;
  logic       boot_fail;
  logic       hb_fail;
  logic       lockout;
  logic [2:0] retry_cnt;
  logic [2:0] state_dbg;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  localparam int BOOT = 100;
  localparam int HBT  = 50;
  localparam int PLEN = 4;

  dsp_boot_monitor #(
    .BOOT_TIMEOUT(20'd100),
    .HB_TIMEOUT(24'd50),
    .MAX_RETRY(3'd2),
    .REQ_PULSE_LEN(8'd4)
  ) dut (
    .clk_sys(clk),
    .hard_rst_n(rst_n),
    .seq_full_n(seq),
    .dsp_rstn_state(rstn_pin),
    .dsp_heartbeat(hb),
    .reseq_req(reseq_req),
    .dsp_ok(dsp_ok),
    .boot_fail(boot_fail),
    .hb_fail(hb_fail),
    .lockout(lockout),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  assign outs = {reseq_req, dsp_ok, boot_fail, hb_fail, lockout, retry_cnt, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seq = 1'b0;
    rstn_pin = 1'b0;
    hb = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    seq = 1'b0;
    rstn_pin = 1'b0;
    hb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0", outs);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle got %0d exp 0", state_dbg);
    end
    seq = 1'b1;
    step();
    checks++;
    if (state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL idle_to_wait got %0d exp 1", state_dbg);
    end
  endtask

  // Release arrives after step r; synced rstn reaches the FSM three edges
  // later, while the boot timeout fires on edge BOOT+1 after seq rises.
  task automatic test_boot(input int r);
    bit run;
    int last;
    do_reset();
    seq = 1'b1;
    run  = (r + 3 <= BOOT + 1);
    last = run ? r + 3 : BOOT + 1;
    for (int i = 1; i <= last; i++) begin
      step();
      if (i == r) rstn_pin = 1'b1;
      if (i == 1) begin
        checks++;
        if (state_dbg !== 3'd1) begin
          errors++;
          $display("FAIL boot_wait r=%0d got %0d exp 1", r, state_dbg);
        end
      end
      if (i == last - 1) begin
        checks++;
        if (dsp_ok !== 1'b0) begin
          errors++;
          $display("FAIL boot_early r=%0d got %b exp 0", r, dsp_ok);
        end
      end
    end
    checks++;
    if (state_dbg !== (run ? 3'd2 : 3'd3) || dsp_ok !== run ||
        boot_fail !== !run || reseq_req !== !run) begin
      errors++;
      $display("FAIL boot_end r=%0d got st=%0d ok=%b bf=%b rq=%b exp st=%0d ok=%b",
               r, state_dbg, dsp_ok, boot_fail, reseq_req, run ? 2 : 3, run);
    end
  endtask

  task automatic test_heartbeat(input int r, input int p, input int n);
    bit drop;
    int width;
    drop = 1'b0;
    test_boot(r);
    for (int k = 1; k <= n * p; k++) begin
      step();
      if (k % p == 0) hb = ~hb;
      if (dsp_ok !== 1'b1) drop = 1'b1;
    end
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL hb_alive_drop p=%0d got %b exp 0", p, drop);
    end
    repeat (HBT + 2) step();
    checks++;
    if (dsp_ok !== 1'b1 || state_dbg !== 3'd2) begin
      errors++;
      $display("FAIL hb_before_to got ok=%b st=%0d exp ok=1 st=2", dsp_ok, state_dbg);
    end
    step();
    checks++;
    if (state_dbg !== 3'd3 || hb_fail !== 1'b1 || dsp_ok !== 1'b0 ||
        reseq_req !== 1'b1 || retry_cnt !== 3'd1 || boot_fail !== 1'b0) begin
      errors++;
      $display("FAIL hb_fault got st=%0d hf=%b ok=%b rq=%b rc=%0d bf=%b exp 3 1 0 1 1 0",
               state_dbg, hb_fail, dsp_ok, reseq_req, retry_cnt, boot_fail);
    end
    width = 1;
    repeat (5) begin
      step();
      if (reseq_req === 1'b1) width++;
    end
    checks++;
    if (width !== PLEN || state_dbg !== 3'd4) begin
      errors++;
      $display("FAIL hb_pulse got w=%0d st=%0d exp w=%0d st=4", width, state_dbg, PLEN);
    end
    repeat (BOOT - 2) step();
    checks++;
    if (lockout !== 1'b0 || state_dbg !== 3'd4) begin
      errors++;
      $display("FAIL seqwait_early got lk=%b st=%0d exp 0 4", lockout, state_dbg);
    end
    step();
    checks++;
    if (lockout !== 1'b1 || state_dbg !== 3'd5 || reseq_req !== 1'b0 || dsp_ok !== 1'b0) begin
      errors++;
      $display("FAIL seqwait_lock got lk=%b st=%0d rq=%b ok=%b exp 1 5 0 0",
               lockout, state_dbg, reseq_req, dsp_ok);
    end
  endtask

  task automatic test_midpulse_reset();
    do_reset();
    seq = 1'b1;
    repeat (BOOT) step();
    checks++;
    if (reseq_req !== 1'b0 || state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL bto_early got rq=%b st=%0d exp 0 1", reseq_req, state_dbg);
    end
    step();
    checks++;
    if (reseq_req !== 1'b1 || state_dbg !== 3'd3 || boot_fail !== 1'b1 ||
        retry_cnt !== 3'd1 || hb_fail !== 1'b0) begin
      errors++;
      $display("FAIL bto_fault got rq=%b st=%0d bf=%b rc=%0d hf=%b exp 1 3 1 1 0",
               reseq_req, state_dbg, boot_fail, retry_cnt, hb_fail);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 11'd0) begin
      errors++;
      $display("FAIL midpulse_rst got %b exp 0", outs);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (state_dbg !== 3'd1 || boot_fail !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume got st=%0d bf=%b exp 1 0", state_dbg, boot_fail);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int a = 0; a < 3; a++) begin
      seq = 1'b1;
      repeat (BOOT + 1) step();
      if (a < 2) begin
        checks++;
        if (reseq_req !== 1'b1 || retry_cnt !== 3'(a + 1)) begin
          errors++;
          $display("FAIL lock_req a=%0d got rq=%b rc=%0d exp 1 %0d",
                   a, reseq_req, retry_cnt, a + 1);
        end
        repeat (PLEN) step();
        seq = 1'b0;
        step();
        checks++;
        if (state_dbg !== 3'd0) begin
          errors++;
          $display("FAIL lock_idle a=%0d got %0d exp 0", a, state_dbg);
        end
      end else begin
        checks++;
        if (reseq_req !== 1'b0 || state_dbg !== 3'd3 || retry_cnt !== 3'd2) begin
          errors++;
          $display("FAIL lock_nopulse got rq=%b st=%0d rc=%0d exp 0 3 2",
                   reseq_req, state_dbg, retry_cnt);
        end
        step();
        checks++;
        if (lockout !== 1'b1 || state_dbg !== 3'd5 || retry_cnt !== 3'd2 || reseq_req !== 1'b0) begin
          errors++;
          $display("FAIL lock_enter got lk=%b st=%0d rc=%0d rq=%b exp 1 5 2 0",
                   lockout, state_dbg, retry_cnt, reseq_req);
        end
      end
    end
    seq = 1'b0;
    rstn_pin = 1'b1;
    repeat (10) begin
      step();
      hb = ~hb;
    end
    checks++;
    if (lockout !== 1'b1 || state_dbg !== 3'd5 || dsp_ok !== 1'b0) begin
      errors++;
      $display("FAIL lock_terminal got lk=%b st=%0d ok=%b exp 1 5 0", lockout, state_dbg, dsp_ok);
    end
  endtask

  task automatic test_running_exits();
    test_boot(10);
    rstn_pin = 1'b0;
    repeat (3) step();
    checks++;
    if (state_dbg !== 3'd1 || dsp_ok !== 1'b0 || hb_fail !== 1'b0) begin
      errors++;
      $display("FAIL run_rstn_drop got st=%0d ok=%b hf=%b exp 1 0 0", state_dbg, dsp_ok, hb_fail);
    end
    rstn_pin = 1'b1;
    repeat (3) step();
    checks++;
    if (state_dbg !== 3'd2 || dsp_ok !== 1'b1) begin
      errors++;
      $display("FAIL run_reenter got st=%0d ok=%b exp 2 1", state_dbg, dsp_ok);
    end
    seq = 1'b0;
    step();
    checks++;
    if (state_dbg !== 3'd0 || dsp_ok !== 1'b0 || boot_fail !== 1'b0 || hb_fail !== 1'b0) begin
      errors++;
      $display("FAIL run_seq_drop got st=%0d ok=%b bf=%b hf=%b exp 0 0 0 0",
               state_dbg, dsp_ok, boot_fail, hb_fail);
    end
  endtask

  initial begin
    test_reset();
    test_boot(30);
    repeat (3) test_boot(int'($urandom_range(1, 95)));
    test_boot(98);
    test_boot(99);
    test_heartbeat(30, 20, 3);
    repeat (2) test_heartbeat(int'($urandom_range(1, 60)),
                              int'($urandom_range(2, 45)),
                              int'($urandom_range(1, 4)));
    test_midpulse_reset();
    test_lockout();
    test_running_exits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
